// File: rtl/result_frame_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// result_frame_tx
//
// Transmit half of the chip's UART link. Frames one result packet and
// serialises it onto TXD as 8N1 UART:
//
//   SYNC_BYTE, length byte (PAYLOAD_LEN), PAYLOAD_LEN payload bytes,
//   [XOR checksum of length + payload bytes]
//
// Payload bytes are pulled one at a time from the result datapath over a
// valid/ready handshake. A payload byte is only requested once the line is
// free again, so every payload byte is preceded by at least one idle (high)
// line cycle. SYNC->LEN and last payload->checksum are sent back-to-back.
//
// Build option:
//   RESULT_TX_CHECKSUM_EN  defined   : checksum byte appended after payload.
//                          undefined : packet ends after the last payload
//                                      byte; no checksum logic is built.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (no fractional correction)
//   PAYLOAD_LEN   payload bytes per packet, 1..255; also the length byte
//   SYNC_BYTE     first byte of every packet
//
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-high reset; abandons any packet
//   START       one-cycle request to send a packet; only honoured when idle
//   DATA_IN     payload byte from the result logic
//   DATA_VALID  DATA_IN is valid
//   DATA_READY  block takes DATA_IN this cycle (high only while fetching)
//   TXD         UART serial output, idles high
//   BUSY        packet in progress
//   DONE        one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module result_frame_tx #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         PAYLOAD_LEN  = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    output logic       TXD,
    output logic       BUSY,
    output logic       DONE
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        LEN_BYTE  = 8'(PAYLOAD_LEN);
    localparam logic [3:0]        STOP_IDX  = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLen,
        StFetch,
        StPay,
        StCsum
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    // Index of the bit currently on the line: 0 = start, 1..8 = data, 9 = stop.
    logic [3:0]        bit_q, bit_d;
    // Whole UART frame {stop, data, start}; bit 0 is what is on the line.
    logic [9:0]        frame_q, frame_d;
    logic [7:0]        pay_cnt_q, pay_cnt_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic sending;
    logic sending_d;
    logic bit_end;
    logic byte_end;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        pay_cnt_d = pay_cnt_q;
        done_d    = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        sending  = (state_q == StSync) || (state_q == StLen) ||
                   (state_q == StPay)  || (state_q == StCsum);
        bit_end  = (baud_q == BAUD_LAST);
        byte_end = sending && bit_end && (bit_q == STOP_IDX);

        // Bit timing common to every byte-sending state.
        if (sending) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q != STOP_IDX) begin
                    bit_d   = bit_q + 4'd1;
                    frame_d = {1'b1, frame_q[9:1]};
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end

        // Any byte load below overrides the counter updates above so the new
        // start bit is on the line from the very next edge.
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d   = StSync;
                    frame_d   = {1'b1, SYNC_BYTE, 1'b0};
                    baud_d    = '0;
                    bit_d     = '0;
                    pay_cnt_d = '0;
`ifdef RESULT_TX_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            StSync: begin
                if (byte_end) begin
                    state_d = StLen;
                    frame_d = {1'b1, LEN_BYTE, 1'b0};
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef RESULT_TX_CHECKSUM_EN
                    csum_d  = csum_q ^ LEN_BYTE;
`endif
                end
            end
            StLen: begin
                if (byte_end) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (DATA_VALID) begin
                    state_d   = StPay;
                    frame_d   = {1'b1, DATA_IN, 1'b0};
                    baud_d    = '0;
                    bit_d     = '0;
                    pay_cnt_d = pay_cnt_q + 8'd1;
`ifdef RESULT_TX_CHECKSUM_EN
                    csum_d    = csum_q ^ DATA_IN;
`endif
                end
            end
            StPay: begin
                if (byte_end) begin
                    if (pay_cnt_q == LEN_BYTE) begin
`ifdef RESULT_TX_CHECKSUM_EN
                        state_d = StCsum;
                        frame_d = {1'b1, csum_q, 1'b0};
                        baud_d  = '0;
                        bit_d   = '0;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
`ifdef RESULT_TX_CHECKSUM_EN
            StCsum: begin
                if (byte_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // TXD is registered from the next-state view so the pin never glitches.
        sending_d = (state_d == StSync) || (state_d == StLen) ||
                    (state_d == StPay)  || (state_d == StCsum);
        txd_d     = sending_d ? frame_d[0] : 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            frame_q   <= '1;
            pay_cnt_q <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            pay_cnt_q <= pay_cnt_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign TXD        = txd_q;
    assign DONE       = done_q;
    assign BUSY       = (state_q != StIdle);
    assign DATA_READY = (state_q == StFetch);

endmodule

// File: tb/tb_result_frame_tx.sv
`timescale 1ns/1ps
// Testbench for result_frame_tx (CLKS_PER_BIT=4, PAYLOAD_LEN=4).
// Expected line bytes are pushed to a queue when a packet is set up; an
// independent UART receiver process decodes TXD and pops/compares.
module tb_result_frame_tx;

    localparam int         CPB  = 4;
    localparam int         PLEN = 4;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NBYTES = PLEN + 3;
`else
    localparam int NBYTES = PLEN + 2;
`endif
    // Unstalled packet: all bytes at 10 bits each, one idle cycle per payload byte, then DONE.
    localparam int BASE_LAT = NBYTES * 10 * CPB + PLEN + 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       DATA_READY;
    logic       TXD;
    logic       BUSY;
    logic       DONE;

    result_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .PAYLOAD_LEN (PLEN),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .DATA_IN   (DATA_IN),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .TXD       (TXD),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    int stall_idx = -1;
    int stall_left = 0;
    int acc = 0;
    bit stall_started = 0;
    bit hs_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the packet as the line should carry it.
    task automatic load_packet(input logic [31:0] pw, input int sidx, input int slen);
        logic [7:0] b;
`ifdef RESULT_TX_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'(PLEN);
`endif
        exp_q.push_back(SYNC);
        exp_q.push_back(8'(PLEN));
        for (int i = 0; i < PLEN; i++) begin
            b = pw[31-8*i -: 8];
            exp_q.push_back(b);
            pay_q.push_back(b);
`ifdef RESULT_TX_CHECKSUM_EN
            sum = sum ^ b;
`endif
        end
`ifdef RESULT_TX_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        acc = 0;
        stall_idx = sidx;
        stall_left = slen;
        stall_started = 0;
    endtask

    // Payload source: presents bytes from pay_q, optionally withholding one.
    initial begin : feeder
        forever begin
            @(negedge CLK);
            if (RESET) begin
                hs_prev = 0;
                DATA_VALID = 1'b0;
            end else begin
                if (hs_prev) begin
                    void'(pay_q.pop_front());
                    acc++;
                end
                if (pay_q.size() > 0 && acc == stall_idx && stall_left > 0) begin
                    DATA_VALID = 1'b0;
                    if (DATA_READY || stall_started) begin
                        check("stall_line_idle", 32'({DATA_READY, TXD}), 32'b11);
                        stall_started = 1;
                        stall_left--;
                    end
                end else begin
                    DATA_VALID = (pay_q.size() > 0);
                    DATA_IN = DATA_VALID ? pay_q[0] : 8'h00;
                end
                hs_prev = DATA_VALID && DATA_READY;
            end
        end
    end

    // UART receiver: every cycle of every bit must hold the same level.
    task automatic rx_frame();
        logic [9:0] bits;
        bit stable;
        bit aborted;
        bits = '0;
        stable = 1;
        aborted = 0;
        for (int i = 0; i < 10 && !aborted; i++) begin
            for (int c = 0; c < CPB && !aborted; c++) begin
                if (i != 0 || c != 0) @(negedge CLK);
                if (RESET) aborted = 1;
                else if (c == 0) bits[i] = TXD;
                else if (TXD !== bits[i]) stable = 0;
            end
        end
        if (!aborted) begin
            check("frame_shape", 32'({stable, bits[0], bits[9]}), 32'b101);
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("line_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!RESET && TXD === 1'b0) rx_frame();
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                done_cnt++;
                check("done_idle", 32'({BUSY, TXD}), 32'b01);
            end
        end
    end

    task automatic run_packet(input int exp_lat, input int mid_start, input bit chain,
                              input bit started);
        int t0;
        bit seen;
        if (!started) begin
            @(negedge CLK);
            START = 1'b1;
        end
        t0 = cyc;
        @(negedge CLK);
        START = 1'b0;
        check("start_bit", 32'({TXD, BUSY}), 32'b01);
        seen = 0;
        while (!seen && (cyc - t0) < exp_lat + 100) begin
            @(negedge CLK);
            if (mid_start > 0) START = ((cyc - t0) == mid_start);
            seen = DONE;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency", 32'(cyc - t0), 32'(exp_lat));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (chain) START = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0;
        int t0;
        logic [31:0] pw;
        int sidx;
        int slen;

        #1 RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_idle", 32'({TXD, BUSY, DONE, DATA_READY}), 32'b1000);
        end
        RESET = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            check("post_reset_idle", 32'({TXD, BUSY, DONE, DATA_READY}), 32'b1000);
        end

        // Nominal packet.
        load_packet(32'h11223344, -1, 0);
        run_packet(BASE_LAT, 0, 0, 0);

        // Third payload byte withheld for 100 cycles.
        load_packet(32'h11223344, 2, 100);
        run_packet(BASE_LAT + 100, 0, 0, 0);

        // START mid-packet is ignored; START in the DONE cycle chains a packet.
        d0 = done_cnt;
        load_packet(32'hDEADBEEF, -1, 0);
        run_packet(BASE_LAT, 150, 1, 0);
        load_packet(32'h0102FF80, -1, 0);
        run_packet(BASE_LAT, 0, 0, 1);
        repeat (20) @(negedge CLK);
        check("one_done_per_packet", 32'(done_cnt - d0), 32'd2);

        // Random payloads with a random stall.
        for (int k = 0; k < 6; k++) begin
            pw = $urandom();
            sidx = $urandom_range(0, PLEN - 1);
            slen = $urandom_range(0, 30);
            load_packet(pw, sidx, slen);
            run_packet(BASE_LAT + slen, 0, 0, 0);
        end

        // Async reset during data bit 3 of payload byte 0x22.
        load_packet(32'h11223344, -1, 0);
        @(negedge CLK);
        START = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        START = 1'b0;
        d0 = done_cnt;
        while ((cyc - t0) < 140) @(negedge CLK);
        #2;
        check("bit3_of_22", 32'({BUSY, TXD}), 32'b10);
        RESET = 1'b1;
        #1;
        check("async_reset_out", 32'({TXD, BUSY, DATA_READY}), 32'b100);
        exp_q.delete();
        pay_q.delete();
        acc = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (400) @(negedge CLK);
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        check("idle_after_abort", 32'({TXD, BUSY, DATA_READY}), 32'b100);
        load_packet(32'h11223344, -1, 0);
        run_packet(BASE_LAT, 0, 0, 0);

        repeat (20) @(negedge CLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
